// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: PS/2 scancodes, joystick bit
// positions, the key-latch index enum and the per-player raw source record.
package arcade_input_pkg;

  // {extended, scancode}
  localparam logic [8:0] SC_P1_UP      = 9'h175;
  localparam logic [8:0] SC_P1_DOWN    = 9'h172;
  localparam logic [8:0] SC_P1_LEFT    = 9'h16B;
  localparam logic [8:0] SC_P1_RIGHT   = 9'h174;
  localparam logic [8:0] SC_P1_BTN0A   = 9'h014;
  localparam logic [8:0] SC_P1_BTN0B   = 9'h029;
  localparam logic [8:0] SC_P1_BTN1    = 9'h011;
  localparam logic [8:0] SC_P1_BTN2    = 9'h012;
  localparam logic [8:0] SC_P2_UP      = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN    = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT    = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT   = 9'h034;
  localparam logic [8:0] SC_P2_BTN0    = 9'h01C;
  localparam logic [8:0] SC_P2_BTN1    = 9'h01B;
  localparam logic [8:0] SC_START1     = 9'h016;
  localparam logic [8:0] SC_START2     = 9'h01E;
  localparam logic [8:0] SC_START1_ALT = 9'h005;
  localparam logic [8:0] SC_START2_ALT = 9'h006;
  localparam logic [8:0] SC_COIN1      = 9'h02E;
  localparam logic [8:0] SC_COIN2      = 9'h036;
  localparam logic [8:0] SC_SERVICE    = 9'h02C;

  // Joystick bit positions within one 16-bit player word
  localparam int unsigned JB_RIGHT = 0;
  localparam int unsigned JB_LEFT  = 1;
  localparam int unsigned JB_DOWN  = 2;
  localparam int unsigned JB_UP    = 3;
  localparam int unsigned JB_BTN0  = 4;

  localparam int unsigned MAX_BUTTONS = 8;

  // One latch per physical key; the two P1 fire keys are kept apart so that
  // releasing one does not drop the other.
  typedef enum logic [4:0] {
    KeyP1Up, KeyP1Down, KeyP1Left, KeyP1Right,
    KeyP1Btn0A, KeyP1Btn0B, KeyP1Btn1, KeyP1Btn2,
    KeyP2Up, KeyP2Down, KeyP2Left, KeyP2Right,
    KeyP2Btn0, KeyP2Btn1,
    KeyStart1, KeyStart2, KeyStart1Alt, KeyStart2Alt,
    KeyCoin1, KeyCoin2, KeyService,
    KeyNone
  } key_e;

  localparam int unsigned NUM_KEYS = 21;

  typedef struct packed {
    logic                   coin;
    logic                   start;
    logic [MAX_BUTTONS-1:0] btn;
    logic                   up;
    logic                   down;
    logic                   left;
    logic                   right;
  } src_t;

  function automatic int unsigned ctrl_width(input int unsigned nb);
    return 4 + nb;
  endfunction

  function automatic key_e key_lookup(input logic [8:0] code);
    key_e k;
    k = KeyNone;
    case (code)
      SC_P1_UP:      k = KeyP1Up;
      SC_P1_DOWN:    k = KeyP1Down;
      SC_P1_LEFT:    k = KeyP1Left;
      SC_P1_RIGHT:   k = KeyP1Right;
      SC_P1_BTN0A:   k = KeyP1Btn0A;
      SC_P1_BTN0B:   k = KeyP1Btn0B;
      SC_P1_BTN1:    k = KeyP1Btn1;
      SC_P1_BTN2:    k = KeyP1Btn2;
      SC_P2_UP:      k = KeyP2Up;
      SC_P2_DOWN:    k = KeyP2Down;
      SC_P2_LEFT:    k = KeyP2Left;
      SC_P2_RIGHT:   k = KeyP2Right;
      SC_P2_BTN0:    k = KeyP2Btn0;
      SC_P2_BTN1:    k = KeyP2Btn1;
      SC_START1:     k = KeyStart1;
      SC_START2:     k = KeyStart2;
      SC_START1_ALT: k = KeyStart1Alt;
      SC_START2_ALT: k = KeyStart2Alt;
      SC_COIN1:      k = KeyCoin1;
      SC_COIN2:      k = KeyCoin2;
      SC_SERVICE:    k = KeyService;
      default:       k = KeyNone;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Host-side bundle for the arcade input mapper. The autofire enable vector
// exists only when ARCADE_INPUT_AUTOFIRE_EN is defined.
interface arcade_input_mapper_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_BUTTONS = 3
);
  import arcade_input_pkg::*;

  logic [10:0]                                        ps2_key;
  logic [16*NUM_PLAYERS-1:0]                          joystick;
  logic                                               rotate;
  logic                                               merge;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [NUM_PLAYERS-1:0]                             autofire;
`endif
  logic [ctrl_width(NUM_BUTTONS)*NUM_PLAYERS-1:0]     ctrl;
  logic [NUM_PLAYERS-1:0]                             start;
  logic [NUM_PLAYERS-1:0]                             coin;
  logic                                               service;

  modport master (
    output ps2_key, joystick, rotate, merge,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    output autofire,
`endif
    input  ctrl, start, coin, service
  );

  modport slave (
    input  ps2_key, joystick, rotate, merge,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  autofire,
`endif
    output ctrl, start, coin, service
  );

endinterface

// File: rtl/arcade_coin_shaper.sv
// Coin pulse shaper: a rising edge on the raw source while idle produces one
// pulse of exactly COIN_PULSE_CYC cycles; edges during a pulse are ignored.
module arcade_coin_shaper #(
  parameter int unsigned COIN_PULSE_CYC = 12000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_src_i,
  output logic coin_o
);

  localparam int unsigned CntW = $clog2(COIN_PULSE_CYC + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(COIN_PULSE_CYC);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            prev_q, prev_d;

  // Down-count while active, otherwise arm on a fresh rising edge.
  always_comb begin
    prev_d = coin_src_i;
    cnt_d  = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CntOne;
    end else if (coin_src_i && !prev_q) begin
      cnt_d = CntLoad;
    end
    if (reset) begin
      prev_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    cnt_q  <= cnt_d;
    prev_q <= prev_d;
  end

  assign coin_o = (cnt_q != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade input mapper: latches PS/2 key events, merges them with HPS joysticks,
// optionally merges all players and rotates directions, shapes coin pulses and
// registers per-player control vectors. Optional feature macro:
// ARCADE_INPUT_AUTOFIRE_EN (adds autofire gating of button 0).
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned NUM_BUTTONS    = 3,
  parameter int unsigned COIN_PULSE_CYC = 12000
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  ,
  parameter int unsigned AUTOFIRE_DIV   = 200000
`endif
) (
  input logic                  clk_sys,
  input logic                  reset,
  arcade_input_mapper_if.slave bus
);

  localparam int unsigned CtrlW = ctrl_width(NUM_BUTTONS);
  localparam logic [MAX_BUTTONS-1:0] BtnMask = MAX_BUTTONS'((1 << NUM_BUTTONS) - 1);

  logic [NUM_KEYS-1:0]          key_q, key_d;
  logic                         old_tog_q, old_tog_d;
  logic [CtrlW*NUM_PLAYERS-1:0] ctrl_q, ctrl_d;
  logic [NUM_PLAYERS-1:0]       start_q, start_d;
  logic                         service_q, service_d;
  logic [NUM_PLAYERS-1:0]       coin_out;
  logic                         unused_bits;

  src_t key_src [NUM_PLAYERS];
  src_t joy_src [NUM_PLAYERS];
  src_t out_src [NUM_PLAYERS];

  // Key event decode: a toggle of ps2_key[10] writes the pressed bit into the
  // matching key latch. old_tog tracks the toggle even in reset.
  always_comb begin
    key_e ev_key;
    ev_key    = key_lookup(bus.ps2_key[8:0]);
    key_d     = key_q;
    old_tog_d = bus.ps2_key[10];
    if ((bus.ps2_key[10] != old_tog_q) && (ev_key != KeyNone)) begin
      key_d[ev_key] = bus.ps2_key[9];
    end
    if (reset) begin
      key_d = '0;
    end
  end

  // Key latch register.
  always_ff @(posedge clk_sys) begin
    key_q     <= key_d;
    old_tog_q <= old_tog_d;
  end

  // Keyboard and joystick contributions per player; only players 1 and 2 have keys.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      logic [15:0] j;
      j          = bus.joystick[16*p +: 16];
      key_src[p] = '0;
      joy_src[p] = '0;
      if (p == 0) begin
        key_src[p].up     = key_q[KeyP1Up];
        key_src[p].down   = key_q[KeyP1Down];
        key_src[p].left   = key_q[KeyP1Left];
        key_src[p].right  = key_q[KeyP1Right];
        key_src[p].btn[0] = key_q[KeyP1Btn0A] | key_q[KeyP1Btn0B];
        key_src[p].btn[1] = key_q[KeyP1Btn1];
        key_src[p].btn[2] = key_q[KeyP1Btn2];
        key_src[p].start  = key_q[KeyStart1] | key_q[KeyStart1Alt];
        key_src[p].coin   = key_q[KeyCoin1];
      end else if (p == 1) begin
        key_src[p].up     = key_q[KeyP2Up];
        key_src[p].down   = key_q[KeyP2Down];
        key_src[p].left   = key_q[KeyP2Left];
        key_src[p].right  = key_q[KeyP2Right];
        key_src[p].btn[0] = key_q[KeyP2Btn0];
        key_src[p].btn[1] = key_q[KeyP2Btn1];
        key_src[p].start  = key_q[KeyStart2] | key_q[KeyStart2Alt];
        key_src[p].coin   = key_q[KeyCoin2];
      end
      joy_src[p].right = j[JB_RIGHT];
      joy_src[p].left  = j[JB_LEFT];
      joy_src[p].down  = j[JB_DOWN];
      joy_src[p].up    = j[JB_UP];
      for (int k = 0; k < NUM_BUTTONS; k++) begin
        joy_src[p].btn[k] = j[JB_BTN0 + k];
      end
      joy_src[p].start = j[JB_BTN0 + NUM_BUTTONS];
      joy_src[p].coin  = j[JB_BTN0 + NUM_BUTTONS + 1];
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AfW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam logic [AfW-1:0] AfLast = AfW'(AUTOFIRE_DIV - 1);

  logic [AfW-1:0] af_cnt_q, af_cnt_d;
  logic           af_phase_q, af_phase_d;

  // Free-running divider; af_phase flips every AUTOFIRE_DIV cycles.
  always_comb begin
    af_cnt_d   = af_cnt_q + AfW'(1);
    af_phase_d = af_phase_q;
    if (af_cnt_q == AfLast) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
    if (reset) begin
      af_cnt_d   = '0;
      af_phase_d = 1'b0;
    end
  end

  // Autofire divider register.
  always_ff @(posedge clk_sys) begin
    af_cnt_q   <= af_cnt_d;
    af_phase_q <= af_phase_d;
  end
`endif

  // Merge (OR across players), then rotate directions; buttons/start/coin untouched.
  always_comb begin
    src_t src [NUM_PLAYERS];
    src_t merged;
    src_t sel;
    merged = '0;
    sel    = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      src[p]     = src_t'(key_src[p] | joy_src[p]);
      src[p].btn = src[p].btn & BtnMask;
      merged     = src_t'(merged | src[p]);
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      sel        = bus.merge ? merged : src[p];
      out_src[p] = sel;
      if (bus.rotate) begin
        out_src[p].up    = sel.left;
        out_src[p].down  = sel.right;
        out_src[p].left  = sel.down;
        out_src[p].right = sel.up;
      end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      if (bus.autofire[p]) begin
        out_src[p].btn[0] = sel.btn[0] & af_phase_q;
      end
`endif
    end
  end

  // Next-state of the registered control outputs.
  always_comb begin
    ctrl_d    = '0;
    start_d   = '0;
    service_d = 1'b0;
    if (!reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        ctrl_d[CtrlW*p +: CtrlW] = {out_src[p].btn[NUM_BUTTONS-1:0], out_src[p].up,
                                    out_src[p].down, out_src[p].left, out_src[p].right};
        start_d[p] = out_src[p].start;
      end
      service_d = key_q[KeyService];
    end
  end

  // Output register.
  always_ff @(posedge clk_sys) begin
    ctrl_q    <= ctrl_d;
    start_q   <= start_d;
    service_q <= service_d;
  end

  // Sink for joystick bits and button slots that have no destination.
  always_comb begin
    unused_bits = ^bus.joystick;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      unused_bits = unused_bits ^ (^out_src[p].btn);
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    arcade_coin_shaper #(
      .COIN_PULSE_CYC(COIN_PULSE_CYC)
    ) u_coin (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .coin_src_i(out_src[p].coin),
      .coin_o    (coin_out[p])
    );
  end

  assign bus.ctrl    = ctrl_q;
  assign bus.start   = start_q;
  assign bus.coin    = coin_out;
  assign bus.service = service_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: vector table, hand-written multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_arcade_input_mapper;

  localparam int unsigned NP  = 2;
  localparam int unsigned NB  = 3;
  localparam int unsigned CPC = 5;
  localparam int unsigned CW  = 4 + NB;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper_if #(.NUM_PLAYERS(NP), .NUM_BUTTONS(NB)) bus ();

  arcade_input_mapper #(
    .NUM_PLAYERS   (NP),
    .NUM_BUTTONS   (NB),
    .COIN_PULSE_CYC(CPC)
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    ,
    .AUTOFIRE_DIV  (4)
`endif
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, code};
  endtask

  // ---------------- behavioural reference model ----------------
  bit              key_down [512];
  bit              m_old_tog;
  bit              m_prev [NP];
  int              m_until [NP];
  int              m_cyc = 0;
  logic [CW*NP-1:0] m_ctrl;
  logic [NP-1:0]   m_start, m_coin;
  logic            m_service;

  // Keyboard state expressed as a joystick-format word for player p.
  function automatic logic [15:0] key_word(input int p);
    logic [15:0] w;
    w = '0;
    if (p == 0) begin
      w[3] = key_down['h175]; w[2] = key_down['h172];
      w[1] = key_down['h16B]; w[0] = key_down['h174];
      w[4] = key_down['h014] | key_down['h029];
      w[5] = key_down['h011]; w[6] = key_down['h012];
      w[4+NB] = key_down['h016] | key_down['h005];
      w[5+NB] = key_down['h02E];
    end else if (p == 1) begin
      w[3] = key_down['h02D]; w[2] = key_down['h02B];
      w[1] = key_down['h023]; w[0] = key_down['h034];
      w[4] = key_down['h01C]; w[5] = key_down['h01B];
      w[4+NB] = key_down['h01E] | key_down['h006];
      w[5+NB] = key_down['h036];
    end
    return w;
  endfunction

  always @(posedge clk_sys) begin
    logic [15:0] w [NP];
    logic [15:0] all;
    logic [15:0] s;
    logic [15:0] r;
    bit          was_active;
    if (reset) begin
      foreach (key_down[i]) key_down[i] = 1'b0;
      m_old_tog = bus.ps2_key[10];
      m_ctrl    = '0;
      m_start   = '0;
      m_service = 1'b0;
      m_cyc++;
      for (int p = 0; p < NP; p++) begin
        m_prev[p]  = 1'b0;
        m_until[p] = 0;
        m_coin[p]  = 1'b0;
      end
    end else begin
      all = '0;
      for (int p = 0; p < NP; p++) begin
        w[p] = (key_word(p) | bus.joystick[16*p +: 16]) & 16'h01FF;
        all  = all | w[p];
      end
      for (int p = 0; p < NP; p++) begin
        s = bus.merge ? all : w[p];
        r = s;
        if (bus.rotate) begin
          r[3] = s[1]; r[2] = s[0]; r[1] = s[2]; r[0] = s[3];
        end
        m_ctrl[CW*p +: CW] = r[CW-1:0];
        m_start[p]         = r[4+NB];
        was_active         = (m_cyc < m_until[p]);
        if (r[5+NB] && !m_prev[p] && !was_active) m_until[p] = m_cyc + 1 + CPC;
        m_prev[p] = r[5+NB];
      end
      m_cyc++;
      for (int p = 0; p < NP; p++) m_coin[p] = (m_cyc < m_until[p]);
      m_service = key_down['h02C];
      if (bus.ps2_key[10] != m_old_tog) key_down[bus.ps2_key[8:0]] = bus.ps2_key[9];
      m_old_tog = bus.ps2_key[10];
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0]      joy;
    logic             rot;
    logic             mrg;
    logic [CW*NP-1:0] ctrl;
    logic [NP-1:0]    start;
  } vec_t;

  vec_t vecs [14];

  logic [8:0] codes [24];

  initial begin
    int highs, rises, first_hi;
    logic prev_c;
    logic [31:0] j;

    vecs[0]  = '{32'h0000_0000, 1'b0, 1'b0, 14'h0000, 2'b00};
    vecs[1]  = '{32'h0000_0002, 1'b0, 1'b0, 14'h0002, 2'b00};
    vecs[2]  = '{32'h0000_0002, 1'b1, 1'b0, 14'h0008, 2'b00};
    vecs[3]  = '{32'h0000_0001, 1'b1, 1'b0, 14'h0004, 2'b00};
    vecs[4]  = '{32'h0000_0008, 1'b1, 1'b0, 14'h0001, 2'b00};
    vecs[5]  = '{32'h0000_0004, 1'b1, 1'b0, 14'h0002, 2'b00};
    vecs[6]  = '{32'h0010_0000, 1'b0, 1'b0, 14'h0800, 2'b00};
    vecs[7]  = '{32'h0010_0000, 1'b0, 1'b1, 14'h0810, 2'b00};
    vecs[8]  = '{32'h0080_0000, 1'b0, 1'b0, 14'h0000, 2'b10};
    vecs[9]  = '{32'h0080_0000, 1'b0, 1'b1, 14'h0000, 2'b11};
    vecs[10] = '{32'h0001_0040, 1'b0, 1'b0, 14'h00C0, 2'b00};
    vecs[11] = '{32'hFE00_FE00, 1'b0, 1'b0, 14'h0000, 2'b00};
    vecs[12] = '{32'h0000_000F, 1'b1, 1'b0, 14'h000F, 2'b00};
    vecs[13] = '{32'h0002_0000, 1'b1, 1'b1, 14'h0408, 2'b00};

    codes = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h014, 9'h029, 9'h011, 9'h012,
              9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B, 9'h016, 9'h01E,
              9'h005, 9'h006, 9'h02E, 9'h036, 9'h02C, 9'h075, 9'h01D, 9'h114};

    bus.ps2_key  = '0;
    bus.joystick = '0;
    bus.rotate   = 1'b0;
    bus.merge    = 1'b0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    bus.autofire = '0;
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("reset_ctrl", bus.ctrl, 0);
    check("reset_start", bus.start, 0);
    check("reset_coin", bus.coin, 0);
    check("reset_service", bus.service, 0);
    reset = 1'b0;

    // Vector table: joystick/rotate/merge, one-cycle latency.
    for (int i = 0; i < 14; i++) begin
      bus.joystick = vecs[i].joy;
      bus.rotate   = vecs[i].rot;
      bus.merge    = vecs[i].mrg;
      @(negedge clk_sys);
      check($sformatf("vec%0d_ctrl", i), bus.ctrl, vecs[i].ctrl);
      check($sformatf("vec%0d_start", i), bus.start, vecs[i].start);
    end
    bus.joystick = '0;
    bus.rotate   = 1'b0;
    bus.merge    = 1'b0;

    // P1 up key: visible two cycles after the toggle, cleared two after release.
    send_key(1'b1, 9'h175);
    @(negedge clk_sys); check("key_up_lat1", bus.ctrl, 14'h0000);
    @(negedge clk_sys); check("key_up_lat2", bus.ctrl, 14'h0008);
    send_key(1'b0, 9'h175);
    @(negedge clk_sys); check("key_up_rel1", bus.ctrl, 14'h0008);
    @(negedge clk_sys); check("key_up_rel2", bus.ctrl, 14'h0000);
    send_key(1'b1, 9'h01D);
    repeat (2) @(negedge clk_sys);
    check("unknown_code", bus.ctrl, 14'h0000);
    send_key(1'b1, 9'h02C);
    repeat (2) @(negedge clk_sys);
    check("service_on", bus.service, 1'b1);
    send_key(1'b0, 9'h02C);
    repeat (2) @(negedge clk_sys);
    check("service_off", bus.service, 1'b0);

    // Coin key held with a release/re-press during the pulse.
    send_key(1'b1, 9'h02E);
    highs = 0; rises = 0; first_hi = -1; prev_c = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_sys);
      if (bus.coin[0]) begin
        highs++;
        if (first_hi < 0) first_hi = i;
      end
      if (bus.coin[0] && !prev_c) rises++;
      prev_c = bus.coin[0];
      check($sformatf("coin_p2_quiet%0d", i), bus.coin[1], 1'b0);
      if (i == 3) send_key(1'b0, 9'h02E);
      if (i == 4) send_key(1'b1, 9'h02E);
    end
    check("coin_high_cycles", highs, CPC);
    check("coin_pulse_count", rises, 1);
    check("coin_first_cycle", first_hi, 2);

    // Reset in the middle of a coin pulse with keys held and toggles during reset.
    send_key(1'b0, 9'h02E);
    repeat (2) @(negedge clk_sys);
    send_key(1'b1, 9'h175);
    repeat (2) @(negedge clk_sys);
    send_key(1'b1, 9'h02E);
    repeat (3) @(negedge clk_sys);
    check("pre_rst_coin", bus.coin[0], 1'b1);
    check("pre_rst_ctrl", bus.ctrl, 14'h0008);
    reset = 1'b1;
    send_key(1'b1, 9'h16B);
    @(negedge clk_sys);
    check("rst_mid_ctrl", bus.ctrl, 0);
    check("rst_mid_start", bus.start, 0);
    check("rst_mid_coin", bus.coin, 0);
    check("rst_mid_service", bus.service, 0);
    send_key(1'b1, 9'h174);
    @(negedge clk_sys);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      check($sformatf("post_rst_ctrl%0d", i), bus.ctrl, 0);
      check($sformatf("post_rst_coin%0d", i), bus.coin, 0);
    end

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys);
      check("rnd_ctrl", bus.ctrl, m_ctrl);
      check("rnd_start", bus.start, m_start);
      check("rnd_coin", bus.coin, m_coin);
      check("rnd_service", bus.service, m_service);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom() & $urandom();
        if ($urandom_range(0, 5) != 0) j[8] = 1'b0;
        if ($urandom_range(0, 5) != 0) j[24] = 1'b0;
        bus.joystick = j;
      end
      if ($urandom_range(0, 15) == 0) bus.rotate = ~bus.rotate;
      if ($urandom_range(0, 15) == 0) bus.merge = ~bus.merge;
      if ($urandom_range(0, 2) == 0)
        send_key(1'($urandom_range(0, 1)), codes[$urandom_range(0, 23)]);
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    begin
      int   last_chg, n_chg;
      logic prev_b;
      reset        = 1'b1;
      bus.joystick = '0;
      bus.rotate   = 1'b0;
      bus.merge    = 1'b0;
      @(negedge clk_sys);
      reset        = 1'b0;
      bus.joystick = 32'h0000_0010;
      bus.autofire = 2'b01;
      @(negedge clk_sys);
      prev_b   = bus.ctrl[4];
      last_chg = -1;
      n_chg    = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk_sys);
        if (bus.ctrl[4] != prev_b) begin
          if (last_chg >= 0) check("af_gap", i - last_chg, 4);
          last_chg = i;
          n_chg++;
          prev_b = bus.ctrl[4];
        end
      end
      check("af_edges", (n_chg >= 8), 1'b1);
      bus.autofire = '0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised successor to per-core keyboard/joystick glue in the emu top level.
- Decodes MiSTer ps2_key events into latched key states and merges them with up to NUM_PLAYERS HPS joysticks.
- Applies screen-rotation remapping and shapes coin pulses.
- Presents registered, active-high per-player control vectors to the arcade core.

Parameters:
- NUM_PLAYERS, 2, player channels, 1..4
- NUM_BUTTONS, 3, fire buttons per player, 1..8
- COIN_PULSE_CYC, 16'd12000, coin output high time in clk_sys cycles (1 ms at 12 MHz), ≥1

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8:0] {extended, scancode}
- joystick  in  16*NUM_PLAYERS  HPS joysticks, player p at [16p+15:16p]; bit map below
- rotate  in  1  1 = rotate directions 90° (horizontal cab on vertical game)
- merge  in  1  1 = OR all player sources into every player
- ctrl  out  (4+NUM_BUTTONS)*NUM_PLAYERS  per player {buttons[NB-1:0], up, down, left, right}, LSB right
- start  out  NUM_PLAYERS  start buttons
- coin  out  NUM_PLAYERS  shaped coin pulses
- service  out  1  service/test key

Behaviour:
- Joystick bit map per player:
  - [0] right, [1] left, [2] down, [3] up
  - [4+k] button k
  - [4+NB] start
  - [5+NB] coin
- Key event detection:
  - Register ps2_key[10] as old_tog.
  - When ps2_key[10] != old_tog, the matching key latch <= ps2_key[9].
  - Unknown codes are ignored.
  - One event per toggle; press and release in the same cycle cannot occur.
- Key table (package constants):
  - P1 directions: E0 75/72/6B/74.
  - P1 button0: 14 or 29. P1 button1: 11. P1 button2: 12.
  - P2 directions: 2D/2B/23/34. P2 button0: 1C. P2 button1: 1B.
  - Start: 16 (P1), 1E (P2), 05 (P1 alias), 06 (P2 alias).
  - Coin: 2E (P1), 36 (P2).
  - Service: 2C.
  - Players ≥2 have no keyboard mapping. Buttons with index ≥ NUM_BUTTONS are dropped.
- Source per player p: src_p = key_latches_p | joystick_p.
- Merge: when merge=1, every player uses OR over all src_p.
- Rotation: when rotate=1, applied after merge:
  - up <= left, down <= right, left <= down, right <= up.
  - rotate=0 passes directions straight through.
  - Buttons, start and coin are never rotated.
- Latency:
  - ctrl, start and service are registered.
  - Joystick change visible 1 cycle later.
  - PS/2 event visible 2 cycles after the toggle edge (latch cycle + output register).
- Coin shaper, per player:
  - Edge-detect the raw coin source.
  - A rising edge while the counter is 0 loads COIN_PULSE_CYC and coin=1.
  - coin stays 1 while the counter is nonzero; the counter decrements each cycle.
  - Edges while active are ignored (no retrigger or extension).
  - A held coin source gives exactly one pulse.
  - The counter width is sized from COIN_PULSE_CYC; no wrap.
- Reset:
  - All outputs are 0 the cycle after reset is asserted.
  - Key latches, coin counters and edge registers are cleared; old_tog <= ps2_key[10], so no spurious event on release.
  - Reset mid-pulse terminates the coin pulse immediately.
- Rotate or merge changes take effect on the next registered output; no glitch hold.

Optional Feature:
- Macro: ARCADE_INPUT_AUTOFIRE_EN.
- When defined:
  - Adds input autofire[NUM_PLAYERS-1:0] and parameter AUTOFIRE_DIV (default 200000).
  - A shared free-running counter toggles an af_phase bit every AUTOFIRE_DIV cycles.
  - For player p with autofire[p]=1, button0 output = src button0 & af_phase.
  - The counter and af_phase reset to 0.
- When not defined: no port, no counter, and button0 passes through unchanged.

Decomposition:
- Package arcade_input_pkg holds:
  - scancode localparams
  - joystick bit-index constants (JB_RIGHT..JB_UP, JB_BTN0)
  - function ctrl_width(nb)
  - typedef for the per-player raw source struct
- One sub-module, arcade_coin_shaper (edge detect + down-counter), instantiated NUM_PLAYERS times.

Test Plan:
- Scenario 1 (P1 up key):
  - Stimulus: event {tog^1, pressed=1, 9'h175}, then release event.
  - Required: P1 ctrl up=1 two cycles after the toggle, back to 0 two cycles after the release.
- Scenario 2 (rotation):
  - Stimulus: rotate=1, joystick P1 bit1 (left)=1.
  - Required: P1 ctrl up=1, left=0 after 1 cycle; with rotate=0 the same input gives left=1.
- Scenario 3 (merge):
  - Stimulus: merge=1, joystick P2 bit4=1.
  - Required: both P1 and P2 button0=1; with merge=0 only P2 button0=1.
- Scenario 4 (coin pulse):
  - Stimulus: COIN_PULSE_CYC=5; key 2E held 100 cycles, with a second press during the pulse.
  - Required: P1 coin high for exactly 5 cycles, once; the second press is ignored.
- Scenario 5 (reset mid-operation):
  - Stimulus: reset during a coin pulse with a key held, and ps2_key[10] toggled while in reset.
  - Required: all outputs 0 next cycle; after reset release no stale event and key latches are 0.
- Scenario 6 (autofire, ARCADE_INPUT_AUTOFIRE_EN):
  - Stimulus: AUTOFIRE_DIV=4, autofire[0]=1, P1 fire held.
  - Required: button0 toggles on for 4 cycles, off for 4 cycles.
